audio_sequencer: RTL
====================

// Module: audio_sequencer
// PURPOSE
//  Parametrised sound-event sequencer: the successor to the single-tone audio FSM.
//  Latches NUM_EVENTS game-event requests (ghost hit, wall, win, lose, ...) and plays the
//  winning event's melody from a parameter table, one note per NOTE_TICKS tick pulses.
//  Supports priority preemption, looping and one-shot melodies, rests, mute and keypad
//  passthrough. Drives the existing tone generator through sound_en/frequency.
// PARAMETERS
//  NUM_EVENTS  4                      event channels; index 0 = highest priority
//  FREQ_W      4                      frequency code width
//  MAX_NOTES   4                      notes per melody slot
//  NOTE_TICKS  2                      tick pulses per note (>=1)
//  MELODY      64'h0004_0006_0135_0579  note n of event e at [(e*MAX_NOTES+n)*FREQ_W +: FREQ_W]; code 0 = rest
//  MEL_LEN     12'h25B                len of event e at [e*LW +: LW], LW=$clog2(MAX_NOTES+1); defaults 3,3,1,1
//  LOOP_MASK   4'b0011                bit e=1: melody e repeats until stopped or preempted
// PORTS
//  clk           in   1                    system clock
//  reset         in   1                    asynchronous, active-high reset
//  event_req     in   NUM_EVENTS           per-channel request; any cycle high sets pending
//  tick          in   1                    1-cycle timebase pulse (e.g. OneSecPulse)
//  stop          in   1                    1-cycle: abort playback, clear all pending
//  mute          in   1                    level: force sound_en=0, sequencing continues
//  key_valid     in   1                    keypad key held
//  key_code      in   FREQ_W               keypad frequency code
//  sound_en      out  1                    tone enable
//  frequency     out  FREQ_W               tone code
//  busy          out  1                    state != IDLE
//  active_event  out  $clog2(NUM_EVENTS)   channel in PLAY (0 otherwise)
//  done          out  1                    1-cycle pulse: one-shot melody finished
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, pending=0, note_idx=0, tick_cnt=0; all outputs 0.
//  - Pending: pending[e] set on edge after event_req[e]=1; cleared when e is loaded into PLAY,
//    when e is preempted, on stop, or when MEL_LEN[e]==0 (ignored, no done).
//  - States: IDLE, PLAY, KEY. Outputs are Moore, decoded from registered state/counters.
//  - IDLE: any pending -> PLAY with lowest pending index, note_idx=0, tick_cnt=0;
//    else key_valid -> KEY. Request in cycle c => sound_en first high in cycle c+2.
//  - PLAY: frequency=MELODY note; sound_en=(note!=0)&&!mute. Each tick increments tick_cnt;
//    on tick with tick_cnt==NOTE_TICKS-1: tick_cnt=0, note_idx+1. After last note
//    (MEL_LEN-1): loop bit set -> note_idx=0; else done=1 for one cycle, -> IDLE.
//  - Preemption: pending[j] with j<active_event -> reload PLAY with j at next edge; aborted
//    event dropped, not resumed; no done. Retrigger of active channel restarts at note 0.
//    Lower-priority requests stay pending and play after a one-shot completes.
//  - Simultaneous requests in one cycle: lowest index plays, others remain pending.
//  - KEY: frequency=key_code, sound_en=key_valid&&!mute; key_valid=0 -> IDLE.
//    Any pending event preempts KEY (-> PLAY next edge).
//  - stop has priority over all: next state IDLE, pending cleared, no done.
//  - tick while IDLE/KEY ignored. tick_cnt width $clog2(NOTE_TICKS)+1, note_idx
//    $clog2(MAX_NOTES)+1; both wrap only via explicit reset to 0, never overflow.
// TESTING
//  1 event_req=4'b1000 pulse, 4 ticks -> freq=4 for 2 ticks, done pulse, busy=0 after.
//  2 event_req=4'b0001 -> freq 9,7,5,9,7,... each for 2 ticks; stop -> IDLE, sound_en=0 next cycle.
//  3 event_req=4'b1100 same cycle -> event2 (freq 6) plays first, then event3 (freq 4); two done pulses.
//  4 event3 playing, event_req[1] pulse -> active_event=1, freq=5 next cycle, no done for event3.
//  5 key_valid=1 key_code=7 -> sound_en=1 freq=7; event_req[2] -> freq=6; mute=1 -> sound_en=0, notes still advance.
//  6 reset asserted mid-melody -> all outputs 0 immediately, pending lost; no playback after release.

Source files
------------

// File: rtl/audio_sequencer.sv
// Sound-event sequencer: latches prioritised event requests and plays each event's
// melody from a parameter table, with preemption, looping, rests, mute and keypad passthrough.
module audio_sequencer #(
  parameter int NUM_EVENTS = 4,
  parameter int FREQ_W     = 4,
  parameter int MAX_NOTES  = 4,
  parameter int NOTE_TICKS = 2,
  parameter logic [NUM_EVENTS*MAX_NOTES*FREQ_W-1:0] MELODY = 64'h0004_0006_0135_0579,
  parameter logic [NUM_EVENTS*$clog2(MAX_NOTES+1)-1:0] MEL_LEN = 12'h25B,
  parameter logic [NUM_EVENTS-1:0] LOOP_MASK = 4'b0011
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_EVENTS-1:0]         event_req,
  input  logic                          tick,
  input  logic                          stop,
  input  logic                          mute,
  input  logic                          key_valid,
  input  logic [FREQ_W-1:0]             key_code,
  output logic                          sound_en,
  output logic [FREQ_W-1:0]             frequency,
  output logic                          busy,
  output logic [$clog2(NUM_EVENTS)-1:0] active_event,
  output logic                          done
);
  localparam int LW = $clog2(MAX_NOTES+1);
  localparam int NW = $clog2(MAX_NOTES)+1;
  localparam int TW = $clog2(NOTE_TICKS)+1;
  localparam int AW = $clog2(NUM_EVENTS);
  localparam int SW = $clog2(NUM_EVENTS*MAX_NOTES);

  typedef enum logic [1:0] {IDLE, PLAY, KEY} state_t;

  logic [FREQ_W-1:0]     mel_tab [NUM_EVENTS*MAX_NOTES];
  logic [LW-1:0]         len_tab [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] len_nz;

  for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_evt
    assign len_tab[e] = MEL_LEN[e*LW +: LW];
    assign len_nz[e]  = |MEL_LEN[e*LW +: LW];
    for (genvar n = 0; n < MAX_NOTES; n++) begin : g_note
      assign mel_tab[e*MAX_NOTES+n] = MELODY[(e*MAX_NOTES+n)*FREQ_W +: FREQ_W];
    end
  end

  state_t                state_q, state_d;
  logic [NUM_EVENTS-1:0] pend_q, pend_d;
  logic [AW-1:0]         act_q, act_d;
  logic [NW-1:0]         note_q, note_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic                  done_q, done_d;

  logic [AW-1:0]         pick_idx;
  logic                  last_note, tick_end;
  logic [SW-1:0]         slot;
  logic [FREQ_W-1:0]     note_code;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      act_q   <= '0;
      note_q  <= '0;
      tcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      note_q  <= note_d;
      tcnt_q  <= tcnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    pick_idx = '0;
    for (int i = NUM_EVENTS-1; i >= 0; i--)
      if (pend_q[i]) pick_idx = AW'(i);
  end

  assign last_note = (int'(note_q) == int'(len_tab[act_q]) - 1);
  assign tick_end  = (int'(tcnt_q) == NOTE_TICKS - 1);

  always_comb begin
    state_d = state_q;
    // zero-length melodies never become pending, so they are silently ignored
    pend_d  = pend_q | (event_req & len_nz);
    act_d   = act_q;
    note_d  = note_q;
    tcnt_d  = tcnt_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      pend_d  = '0;
      note_d  = '0;
      tcnt_d  = '0;
    end else if ((|pend_q) && (state_q != PLAY || pick_idx <= act_q)) begin
      // covers start from IDLE, KEY preemption, higher-priority preemption and retrigger
      state_d          = PLAY;
      act_d            = pick_idx;
      note_d           = '0;
      tcnt_d           = '0;
      pend_d[pick_idx] = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (key_valid) state_d = KEY;
        KEY:  if (!key_valid) state_d = IDLE;
        PLAY: begin
          if (tick) begin
            if (tick_end) begin
              tcnt_d = '0;
              if (!last_note) begin
                note_d = note_q + 1'b1;
              end else begin
                note_d = '0;
                if (!LOOP_MASK[act_q]) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                end
              end
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign slot      = SW'(int'(act_q) * MAX_NOTES + int'(note_q));
  assign note_code = mel_tab[slot];

  always_comb begin
    sound_en     = 1'b0;
    frequency    = '0;
    active_event = '0;
    case (state_q)
      PLAY: begin
        frequency    = note_code;
        sound_en     = (note_code != '0) && !mute;
        active_event = act_q;
      end
      KEY: begin
        frequency = key_code;
        sound_en  = key_valid && !mute;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule
